// File: rtl/receiver_pkg.sv
// ---------------------------------------------------------------------------
// receiver_pkg
// Shared constants and types for the receiver frame synchroniser.
//   BYTE_W                  : width of a payload / length byte
//   SYNC_W                  : width of the frame marker
//   DEF_SAMPLES_PER_SYMBOL  : default clocks per transmitted bit
//   DEF_SLICE_THRESHOLD     : default slicer decision level
//   DEF_SYNC_WORD           : default frame marker, searched MSB-first
//   rx_state_t              : framing state machine encoding
// ---------------------------------------------------------------------------
package receiver_pkg;

   localparam int BYTE_W = 8;
   localparam int SYNC_W = 16;

   localparam int              DEF_SAMPLES_PER_SYMBOL = 8;
   localparam logic [7:0]      DEF_SLICE_THRESHOLD    = 8'h80;
   localparam logic [SYNC_W-1:0] DEF_SYNC_WORD        = 16'hA5C3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HUNT,
      ST_LEN,
      ST_PAYLOAD
   } rx_state_t;

endpackage

// File: rtl/receiver_frame_sync_if.sv
// ---------------------------------------------------------------------------
// receiver_frame_sync_if
// Valid/ready byte stream leaving the frame synchroniser.
//   rx_data  : received payload byte
//   rx_valid : rx_data holds a byte not yet taken
//   rx_ready : consumer takes the byte when rx_valid && rx_ready
//   rx_last  : rx_data is the final payload byte of its frame
// master = byte producer (the receiver), slave = byte consumer.
// ---------------------------------------------------------------------------
interface receiver_frame_sync_if import receiver_pkg::*; ();

   logic [BYTE_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              rx_last;

   modport master (
      output rx_data,
      output rx_valid,
      output rx_last,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  rx_last,
      output rx_ready
   );

endinterface

// File: rtl/receiver_symbol_timing.sv
// ---------------------------------------------------------------------------
// receiver_symbol_timing
// Slices the ADC sample stream to bits and recovers the symbol timing.
//   clock      : rising-edge clock, one ADC sample per cycle
//   resetN     : synchronous active-low reset
//   sample     : unsigned ADC sample
//   strobe     : high for one cycle in the middle of each symbol
//   symbol_bit : decided bit, valid when strobe is high
// SAMPLES_PER_SYMBOL is expected to be even and within 4..64.
// ---------------------------------------------------------------------------
module receiver_symbol_timing import receiver_pkg::*; #(
   parameter int         SAMPLES_PER_SYMBOL = DEF_SAMPLES_PER_SYMBOL,
   parameter logic [7:0] SLICE_THRESHOLD    = DEF_SLICE_THRESHOLD
) (
   input  logic              clock,
   input  logic              resetN,
   input  logic [BYTE_W-1:0] sample,
   output logic              strobe,
   output logic              symbol_bit
);

   localparam int               CNT_W    = $clog2(SAMPLES_PER_SYMBOL);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYMBOL - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(SAMPLES_PER_SYMBOL / 2);

   logic             slice_now;
   logic             sliced;
   logic [CNT_W-1:0] phase;

   assign slice_now = (sample >= SLICE_THRESHOLD);

   // The sliced bit is registered once. The phase counter is zeroed in the
   // same cycle a new sliced level first appears, so phase 0 always marks the
   // first sample of a symbol after an edge; between edges it free-runs with
   // the symbol period so long runs of equal bits keep their alignment.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         sliced <= 1'b0;
         phase  <= '0;
      end else begin
         sliced <= slice_now;
         if (slice_now != sliced) begin
            phase <= '0;
         end else if (phase == CNT_LAST) begin
            phase <= '0;
         end else begin
            phase <= phase + 1'b1;
         end
      end
   end

   // Deciding at the half-symbol point keeps the sample furthest from both
   // edges of the bit.
   assign strobe     = (phase == CNT_MID);
   assign symbol_bit = sliced;

endmodule

// File: rtl/receiver_frame_sync.sv
// ---------------------------------------------------------------------------
// receiver_frame_sync
// Finds SYNC_WORD in the sliced bit stream, reads a length byte, then
// delivers that many payload bytes on a valid/ready byte interface.
//   clock             : rising-edge clock
//   resetN            : synchronous active-low reset
//   receiver_sync_in  : enable; low forces the framer to IDLE
//   receiver_ad       : ADC sample of the sender output, one per clock
//   rx                : byte stream (master side)
//   receiver_sync_out : high while locked to a frame (LEN, PAYLOAD)
//   rx_overflow       : one-cycle pulse when a completed byte is dropped
// ---------------------------------------------------------------------------
module receiver_frame_sync import receiver_pkg::*; #(
   parameter int                SAMPLES_PER_SYMBOL = DEF_SAMPLES_PER_SYMBOL,
   parameter logic [7:0]        SLICE_THRESHOLD    = DEF_SLICE_THRESHOLD,
   parameter logic [SYNC_W-1:0] SYNC_WORD          = DEF_SYNC_WORD
) (
   input  logic                        clock,
   input  logic                        resetN,
   input  logic                        receiver_sync_in,
   input  logic [BYTE_W-1:0]           receiver_ad,
   receiver_frame_sync_if.master       rx,
   output logic                        receiver_sync_out,
   output logic                        rx_overflow
);

   localparam logic [2:0] LAST_BIT = 3'(BYTE_W - 1);

   logic              strobe;
   logic              symbol_bit;
   rx_state_t         state;
   logic [SYNC_W-1:0] hunt_reg;
   logic [BYTE_W-1:0] shift_byte;
   logic [2:0]        bit_cnt;
   logic [BYTE_W-1:0] remaining;
   logic [SYNC_W-1:0] next_hunt;
   logic [BYTE_W-1:0] next_byte;
   logic              byte_done;
   logic              out_free;

   receiver_symbol_timing #(
      .SAMPLES_PER_SYMBOL (SAMPLES_PER_SYMBOL),
      .SLICE_THRESHOLD    (SLICE_THRESHOLD)
   ) u_timing (
      .clock      (clock),
      .resetN     (resetN),
      .sample     (receiver_ad),
      .strobe     (strobe),
      .symbol_bit (symbol_bit)
   );

   // Values the shift registers take if this cycle's strobe is accepted.
   assign next_hunt = {hunt_reg[SYNC_W-2:0], symbol_bit};
   assign next_byte = {shift_byte[BYTE_W-2:0], symbol_bit};
   assign byte_done = strobe && (bit_cnt == LAST_BIT);

   // The output slot can take a new byte if empty or being drained this cycle.
   assign out_free  = !rx.rx_valid || rx.rx_ready;

   // Framing state machine and output register. Every output is registered
   // here, so a byte completing on a strobe shows up on rx_data the cycle
   // after that strobe. A completed byte that finds the slot still occupied
   // is dropped and flagged, but the frame keeps counting so the framer
   // stays aligned with the sender. Dropping the enable behaves like a soft
   // reset of the framer that leaves rx_data/rx_last as they were.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         state             <= ST_IDLE;
         hunt_reg          <= '0;
         shift_byte        <= '0;
         bit_cnt           <= '0;
         remaining         <= '0;
         rx.rx_data        <= '0;
         rx.rx_valid       <= 1'b0;
         rx.rx_last        <= 1'b0;
         receiver_sync_out <= 1'b0;
         rx_overflow       <= 1'b0;
      end else if (!receiver_sync_in) begin
         state             <= ST_IDLE;
         hunt_reg          <= '0;
         shift_byte        <= '0;
         bit_cnt           <= '0;
         remaining         <= '0;
         rx.rx_valid       <= 1'b0;
         receiver_sync_out <= 1'b0;
         rx_overflow       <= 1'b0;
      end else begin
         rx_overflow <= 1'b0;
         if (rx.rx_valid && rx.rx_ready) begin
            rx.rx_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               state             <= ST_HUNT;
               hunt_reg          <= '0;
               receiver_sync_out <= 1'b0;
            end

            ST_HUNT: begin
               if (strobe) begin
                  hunt_reg <= next_hunt;
                  if (next_hunt == SYNC_WORD) begin
                     state             <= ST_LEN;
                     bit_cnt           <= '0;
                     receiver_sync_out <= 1'b1;
                  end
               end
            end

            ST_LEN: begin
               if (strobe) begin
                  shift_byte <= next_byte;
                  bit_cnt    <= bit_cnt + 3'd1;
                  if (byte_done) begin
                     if (next_byte == '0) begin
                        state             <= ST_HUNT;
                        hunt_reg          <= '0;
                        receiver_sync_out <= 1'b0;
                     end else begin
                        state     <= ST_PAYLOAD;
                        remaining <= next_byte;
                     end
                  end
               end
            end

            ST_PAYLOAD: begin
               if (strobe) begin
                  shift_byte <= next_byte;
                  bit_cnt    <= bit_cnt + 3'd1;
                  if (byte_done) begin
                     // remaining is never 0 while in PAYLOAD, so the
                     // decrement cannot wrap.
                     remaining <= remaining - 8'd1;
                     if (out_free) begin
                        rx.rx_data  <= next_byte;
                        rx.rx_last  <= (remaining == 8'd1);
                        rx.rx_valid <= 1'b1;
                     end else begin
                        rx_overflow <= 1'b1;
                     end
                     if (remaining == 8'd1) begin
                        state             <= ST_HUNT;
                        hunt_reg          <= '0;
                        receiver_sync_out <= 1'b0;
                     end
                  end
               end
            end

            default: begin
               state             <= ST_IDLE;
               receiver_sync_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_receiver_frame_sync.sv
// ---------------------------------------------------------------------------
// tb_receiver_frame_sync
// Drives NRZ frames (8 clocks per bit, levels 8'h20 / 8'hE0) into
// receiver_frame_sync and checks the delivered byte stream against a queue
// of expected {last, data} entries built from the transmitted frames.
// ---------------------------------------------------------------------------
module tb_receiver_frame_sync;

   localparam logic [15:0] GOOD_SYNC = 16'hA5C3;
   localparam logic [7:0]  LVL_LO    = 8'h20;
   localparam logic [7:0]  LVL_HI    = 8'hE0;

   typedef struct {
      logic [15:0] sync;
      logic [7:0]  len;
      logic [23:0] bytes;
      int          nsent;
      int          exp_ovf;
      logic        exp_lock;
   } vec_t;

   logic       clock = 1'b0;
   logic       resetN;
   logic       receiver_sync_in;
   logic [7:0] receiver_ad;
   logic       receiver_sync_out;
   logic       rx_overflow;

   int         n_checks  = 0;
   int         n_pass    = 0;
   int         ovf_count = 0;
   logic [8:0] exp_q[$];
   logic [8:0] mon_exp;
   vec_t       vecs[6];

   receiver_frame_sync_if rx_if();

   receiver_frame_sync dut (
      .clock             (clock),
      .resetN            (resetN),
      .receiver_sync_in  (receiver_sync_in),
      .receiver_ad       (receiver_ad),
      .rx                (rx_if),
      .receiver_sync_out (receiver_sync_out),
      .rx_overflow       (rx_overflow)
   );

   always #5 clock = ~clock;

   // Generic compare with pass/fail accounting.
   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // One ADC sample per clock, driven well after the rising edge.
   task automatic applyStimulus(input logic [7:0] ad);
      @(posedge clock);
      #2;
      receiver_ad = ad;
   endtask

   task automatic send_bit(input logic b);
      repeat (8) applyStimulus(b ? LVL_HI : LVL_LO);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic idle_bits(input int n);
      repeat (n) send_bit(1'b0);
   endtask

   function automatic logic [7:0] byte_of(input logic [23:0] b, input int i);
      logic [23:0] s;
      s = b << (8 * i);
      return s[23:16];
   endfunction

   // Transmits one table frame, queues what a ready consumer must receive,
   // and checks lock, unlock, overflow count and that the queue drained.
   task automatic run_frame(input vec_t v, input int k);
      ovf_count = 0;
      idle_bits(3);
      if (v.sync == GOOD_SYNC) begin
         for (int i = 0; i < int'(v.len) && i < 3; i++) begin
            exp_q.push_back({(i == int'(v.len) - 1), byte_of(v.bytes, i)});
         end
      end
      send_byte(v.sync[15:8]);
      send_byte(v.sync[7:0]);
      checkOutput($sformatf("lock_after_sync[%0d]", k), 32'(receiver_sync_out), 32'(v.exp_lock));
      send_byte(v.len);
      for (int i = 0; i < v.nsent; i++) send_byte(byte_of(v.bytes, i));
      idle_bits(4);
      checkOutput($sformatf("unlock_after_frame[%0d]", k), 32'(receiver_sync_out), 32'd0);
      checkOutput($sformatf("overflow_count[%0d]", k), 32'(ovf_count), 32'(v.exp_ovf));
      checkOutput($sformatf("bytes_drained[%0d]", k), 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard side: every cycle the consumer takes a byte, it must match
   // the oldest expected entry; a byte with nothing expected is a failure.
   always @(negedge clock) begin
      if (rx_overflow === 1'b1) ovf_count++;
      if (rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_byte: got data %0h last %0b, expected no byte",
                     rx_if.rx_data, rx_if.rx_last);
         end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("rx_byte", {23'd0, rx_if.rx_last, rx_if.rx_data}, {23'd0, mon_exp});
         end
      end
   end

   // Hard bound on simulated time.
   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{16'hA5C3, 8'h03, 24'h112233, 3, 0, 1'b1};
      vecs[1] = '{16'hA5C3, 8'h00, 24'h000000, 0, 0, 1'b1};
      vecs[2] = '{16'hA5C3, 8'h03, 24'h112233, 3, 0, 1'b1};
      vecs[3] = '{16'hA5C3, 8'h01, 24'h5A0000, 1, 0, 1'b1};
      vecs[4] = '{16'hA5C2, 8'h03, 24'h112233, 3, 0, 1'b0};
      vecs[5] = '{16'hA5C3, 8'h03, 24'hFF0080, 3, 0, 1'b1};

      resetN           = 1'b0;
      receiver_sync_in = 1'b0;
      receiver_ad      = LVL_LO;
      rx_if.rx_ready   = 1'b1;

      // Reset values.
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("reset_rx_valid", 32'(rx_if.rx_valid), 32'd0);
      checkOutput("reset_rx_data", 32'(rx_if.rx_data), 32'd0);
      checkOutput("reset_rx_last", 32'(rx_if.rx_last), 32'd0);
      checkOutput("reset_sync_out", 32'(receiver_sync_out), 32'd0);
      checkOutput("reset_overflow", 32'(rx_overflow), 32'd0);
      @(posedge clock);
      #2;
      resetN           = 1'b1;
      receiver_sync_in = 1'b1;

      for (int k = 0; k < 6; k++) run_frame(vecs[k], k);

      // Consumer stalled for a whole frame: first byte held, two dropped.
      rx_if.rx_ready = 1'b0;
      ovf_count      = 0;
      idle_bits(3);
      send_byte(8'hA5); send_byte(8'hC3); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      idle_bits(4);
      checkOutput("stall_rx_valid", 32'(rx_if.rx_valid), 32'd1);
      checkOutput("stall_rx_data", 32'(rx_if.rx_data), 32'h11);
      checkOutput("stall_rx_last", 32'(rx_if.rx_last), 32'd0);
      checkOutput("stall_overflow_count", 32'(ovf_count), 32'd2);
      checkOutput("stall_unlock", 32'(receiver_sync_out), 32'd0);
      exp_q.push_back({1'b0, 8'h11});
      rx_if.rx_ready = 1'b1;
      repeat (4) applyStimulus(LVL_LO);
      checkOutput("stall_drained", 32'(exp_q.size()), 32'd0);
      checkOutput("stall_valid_cleared", 32'(rx_if.rx_valid), 32'd0);

      // Enable dropped after the second payload byte while it is pending.
      idle_bits(3);
      exp_q.push_back({1'b0, 8'hAA});
      send_byte(8'hA5); send_byte(8'hC3); send_byte(8'h03);
      send_byte(8'hAA);
      rx_if.rx_ready = 1'b0;
      send_byte(8'hBB);
      checkOutput("drop_pending_valid", 32'(rx_if.rx_valid), 32'd1);
      checkOutput("drop_pending_data", 32'(rx_if.rx_data), 32'hBB);
      @(posedge clock);
      #2;
      receiver_sync_in = 1'b0;
      @(posedge clock);
      @(negedge clock);
      checkOutput("drop_rx_valid", 32'(rx_if.rx_valid), 32'd0);
      checkOutput("drop_sync_out", 32'(receiver_sync_out), 32'd0);
      rx_if.rx_ready = 1'b1;
      send_byte(8'hCC);
      idle_bits(2);
      receiver_sync_in = 1'b1;
      run_frame('{16'hA5C3, 8'h02, 24'h7E8100, 2, 0, 1'b1}, 10);

      // One-cycle reset in the middle of the payload with a byte pending.
      idle_bits(3);
      rx_if.rx_ready = 1'b0;
      send_byte(8'hA5); send_byte(8'hC3); send_byte(8'h03);
      send_byte(8'h44);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      checkOutput("prereset_valid", 32'(rx_if.rx_valid), 32'd1);
      checkOutput("prereset_lock", 32'(receiver_sync_out), 32'd1);
      @(posedge clock);
      #2;
      resetN = 1'b0;
      @(posedge clock);
      @(negedge clock);
      checkOutput("midreset_rx_valid", 32'(rx_if.rx_valid), 32'd0);
      checkOutput("midreset_rx_data", 32'(rx_if.rx_data), 32'd0);
      checkOutput("midreset_rx_last", 32'(rx_if.rx_last), 32'd0);
      checkOutput("midreset_sync_out", 32'(receiver_sync_out), 32'd0);
      checkOutput("midreset_overflow", 32'(rx_overflow), 32'd0);
      #1;
      resetN         = 1'b1;
      rx_if.rx_ready = 1'b1;
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_byte(8'h66);
      idle_bits(2);
      checkOutput("postreset_no_lock", 32'(receiver_sync_out), 32'd0);
      run_frame('{16'hA5C3, 8'h03, 24'h0F1E2D, 3, 0, 1'b1}, 11);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
